// File: rtl/clock_pkg.sv
// Shared definitions for the clock display stages (seconds and min/hour).
//
// Contents:
//   bcd_t        one BCD digit (4 bits)
//   bcd2_t       a tens/units BCD digit pair
//   set_state_e  time-setting mode FSM states
//   SEG_*        active-low 7-segment codes, bit6..bit0 = a..g
//   bcd2_inc     increment a BCD pair with wrap at a given maximum
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd2_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_MIN  = 2'd1,
    SET_HOUR = 2'd2
  } set_state_e;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Units roll 9->0 carrying into tens; the whole pair returns to 00 once it
  // has reached max_v. Digit-wise, so no binary/BCD conversion is needed.
  function automatic bcd2_t bcd2_inc(bcd2_t v, bcd2_t max_v);
    bcd2_t r;
    if (v == max_v) begin
      r = '0;
    end else if (v.units == 4'd9) begin
      r.tens  = v.tens + 4'd1;
      r.units = 4'd0;
    end else begin
      r.tens  = v.tens;
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder.
//
// Ports:
//   digit  in   4  BCD digit 0..9
//   seg    out  7  segments a..g (bit6..bit0), active-low; non-BCD shows a dash
module bcd_to_seg7
  import clock_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/count_display_min_hour.sv
// Minutes/hours stage of the clock: counts time-of-day minutes and hours from
// the seconds-stage carry, keeps a stopwatch minute count, lets the user set
// the time through a small mode FSM, and drives four registered 7-segment
// digits.
//
// Optional build macro TWELVE_HOUR_EN: hours still count 0..23 internally but
// are displayed 12,1..11,12,1..11 with a blank leading zero, and a pm output
// is added. Without it the display is 24-hour with a leading zero.
//
// Ports:
//   clk           in   1  system clock
//   reset         in   1  synchronous, active-low reset
//   sec_tc        in   1  pulse: seconds wrapped 59->0
//   stopwatch_tc  in   1  pulse: stopwatch seconds wrapped
//   stopwatch     in   1  display select: 1 = stopwatch minutes, 0 = time
//   sw_clear      in   1  pulse: clear stopwatch minutes
//   set_mode      in   1  pulse: advance RUN->SET_MIN->SET_HOUR->RUN
//   inc           in   1  pulse: increment the field being set
//   disp_min      out  7  minute units segments (active-low)
//   disp_min10    out  7  minute tens segments
//   disp_hour     out  7  hour units segments
//   disp_hour10   out  7  hour tens segments
//   day_tc        out  1  one-cycle pulse after the day wraps to 00:00
//   set_active    out  1  high while the FSM is not in RUN
//   state_dbg     out  2  current FSM state (set_state_e encoding)
//   pm            out  1  (TWELVE_HOUR_EN only) 1 for hours 12..23
module count_display_min_hour
  import clock_pkg::*;
#(
  parameter int HOURS_PER_DAY = 24,
  parameter int SW_MIN_MAX    = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tc,
  input  logic       stopwatch_tc,
  input  logic       stopwatch,
  input  logic       sw_clear,
  input  logic       set_mode,
  input  logic       inc,
  output logic [6:0] disp_min,
  output logic [6:0] disp_min10,
  output logic [6:0] disp_hour,
  output logic [6:0] disp_hour10,
  output logic       day_tc,
  output logic       set_active,
  output logic [1:0] state_dbg
`ifdef TWELVE_HOUR_EN
  ,
  output logic       pm
`endif
);

  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = bcd2_t'({4'((HOURS_PER_DAY - 1) / 10),
                                        4'((HOURS_PER_DAY - 1) % 10)});
  localparam bcd2_t SW_MAX   = bcd2_t'({4'(SW_MIN_MAX / 10),
                                        4'(SW_MIN_MAX % 10)});

  set_state_e state, state_d;
  bcd2_t      min_q, min_d;
  bcd2_t      hour_q, hour_d;
  bcd2_t      sw_q, sw_d;
  logic       day_d;

  // Next state and counter updates.
  always_comb begin
    state_d = state;
    min_d   = min_q;
    hour_d  = hour_q;
    day_d   = 1'b0;

    if (set_mode) begin
      case (state)
        RUN:     state_d = SET_MIN;
        SET_MIN: state_d = SET_HOUR;
        default: state_d = RUN;
      endcase
    end

    // Time only advances from the seconds carry while running.
    if (state == RUN && sec_tc) begin
      min_d = bcd2_inc(min_q, MIN_MAX);
      if (min_q == MIN_MAX) begin
        hour_d = bcd2_inc(hour_q, HOUR_MAX);
        day_d  = (hour_q == HOUR_MAX);
      end
    end

    // inc acts on the field of the state being entered, so a set_mode+inc
    // pair moves to the next field and bumps it in one go. No cross-field
    // carry while setting.
    if (inc) begin
      if (state_d == SET_MIN) begin
        min_d = bcd2_inc(min_q, MIN_MAX);
      end else if (state_d == SET_HOUR) begin
        hour_d = bcd2_inc(hour_q, HOUR_MAX);
      end
    end

    // Stopwatch runs in every state; clear wins over a coincident carry.
    sw_d = sw_q;
    if (sw_clear) begin
      sw_d = '0;
    end else if (stopwatch_tc) begin
      sw_d = bcd2_inc(sw_q, SW_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= RUN;
      min_q  <= '0;
      hour_q <= '0;
      sw_q   <= '0;
      day_tc <= 1'b0;
    end else begin
      state  <= state_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      sw_q   <= sw_d;
      day_tc <= day_d;
    end
  end

  assign set_active = (state != RUN);
  assign state_dbg  = state;

  // Hour value as shown on the display.
  bcd2_t hour_disp;
  logic  hour_tens_blank;

`ifdef TWELVE_HOUR_EN
  logic [4:0] hour_bin;
  logic [4:0] hour_12;
  logic       pm_d;

  always_comb begin
    hour_bin = 5'(hour_q.tens) * 5'd10 + 5'(hour_q.units);
    if (hour_bin == 5'd0) begin
      hour_12 = 5'd12;
    end else if (hour_bin > 5'd12) begin
      hour_12 = hour_bin - 5'd12;
    end else begin
      hour_12 = hour_bin;
    end
    if (hour_12 >= 5'd10) begin
      hour_disp.tens  = 4'd1;
      hour_disp.units = 4'(hour_12 - 5'd10);
    end else begin
      hour_disp.tens  = 4'd0;
      hour_disp.units = 4'(hour_12);
    end
    hour_tens_blank = (hour_disp.tens == 4'd0);
    pm_d            = (hour_bin >= 5'd12);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pm <= 1'b0;
    end else begin
      pm <= pm_d;
    end
  end
`else
  assign hour_disp       = hour_q;
  assign hour_tens_blank = 1'b0;
`endif

  bcd2_t      min_sel;
  logic [6:0] seg_min, seg_min10, seg_hour, seg_hour10;

  assign min_sel = stopwatch ? sw_q : min_q;

  bcd_to_seg7 u_dec_min    (.digit(min_sel.units),   .seg(seg_min));
  bcd_to_seg7 u_dec_min10  (.digit(min_sel.tens),    .seg(seg_min10));
  bcd_to_seg7 u_dec_hour   (.digit(hour_disp.units), .seg(seg_hour));
  bcd_to_seg7 u_dec_hour10 (.digit(hour_disp.tens),  .seg(seg_hour10));

  // Display registers: one cycle behind the counters and the select input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_min    <= SEG_0;
      disp_min10  <= SEG_0;
      disp_hour   <= SEG_0;
      disp_hour10 <= SEG_0;
    end else begin
      disp_min    <= seg_min;
      disp_min10  <= seg_min10;
      disp_hour   <= stopwatch ? SEG_DASH : seg_hour;
      disp_hour10 <= stopwatch ? SEG_DASH :
                     (hour_tens_blank ? SEG_BLANK : seg_hour10);
    end
  end

endmodule

// File: tb/tb_count_display_min_hour.sv
// Bench for count_display_min_hour: table of stimulus rows with expected
// minute/hour values, plus hand sequences for latency, day wrap and reset
// while setting.
module tb_count_display_min_hour;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_tc = 1'b0, stopwatch_tc = 1'b0, stopwatch = 1'b0;
  logic       sw_clear = 1'b0, set_mode = 1'b0, inc = 1'b0;
  logic [6:0] disp_min, disp_min10, disp_hour, disp_hour10;
  logic       day_tc, set_active;
  logic [1:0] state_dbg;
`ifdef TWELVE_HOUR_EN
  logic       pm;
`endif

  int errors = 0;
  int checks = 0;

  count_display_min_hour dut (
    .clk(clk), .reset(reset), .sec_tc(sec_tc), .stopwatch_tc(stopwatch_tc),
    .stopwatch(stopwatch), .sw_clear(sw_clear), .set_mode(set_mode), .inc(inc),
    .disp_min(disp_min), .disp_min10(disp_min10), .disp_hour(disp_hour),
    .disp_hour10(disp_hour10), .day_tc(day_tc), .set_active(set_active),
    .state_dbg(state_dbg)
`ifdef TWELVE_HOUR_EN
    , .pm(pm)
`endif
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  sw_view;
    logic  sec, swtc, clr, mode, incr;
    int    reps;
    int    exp_min;   // stopwatch minutes when sw_view is set
    int    exp_hour;
    logic  exp_set;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic sv, logic s, logic st, logic c,
                              logic m, logic i, int r, int em, int eh, logic es);
    vec_t v;
    v.name = n; v.sw_view = sv; v.sec = s; v.swtc = st; v.clr = c;
    v.mode = m; v.incr = i; v.reps = r; v.exp_min = em; v.exp_hour = eh;
    v.exp_set = es;
    vecs.push_back(v);
  endfunction

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  function automatic logic [27:0] exp_disp(logic sv, int m, int h);
    logic [6:0] h10, h1;
    if (sv) begin
      h10 = 7'b1111110;
      h1  = 7'b1111110;
    end else begin
`ifdef TWELVE_HOUR_EN
      int hh;
      hh  = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
      h10 = (hh >= 10) ? seg_of(1) : 7'b1111111;
      h1  = seg_of(hh % 10);
`else
      h10 = seg_of(h / 10);
      h1  = seg_of(h % 10);
`endif
    end
    return {h10, h1, seg_of(m / 10), seg_of(m % 10)};
  endfunction

  // scoreboard
  task automatic check(string name, logic [27:0] act, logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_disp(string name, logic sv, int m, int h);
    check(name, {disp_hour10, disp_hour, disp_min10, disp_min}, exp_disp(sv, m, h));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: reps consecutive pulse cycles, one idle cycle, then compare
  task automatic apply_vec(input vec_t v);
    stopwatch = v.sw_view;
    for (int i = 0; i < v.reps; i++) begin
      sec_tc = v.sec; stopwatch_tc = v.swtc; sw_clear = v.clr;
      set_mode = v.mode; inc = v.incr;
      step();
      sec_tc = 0; stopwatch_tc = 0; sw_clear = 0; set_mode = 0; inc = 0;
    end
    step();
    check_disp({v.name, "_disp"}, v.sw_view, v.exp_min, v.exp_hour);
    check({v.name, "_set_active"}, 28'(set_active), 28'(v.exp_set));
    check({v.name, "_day_tc"}, 28'(day_tc), 28'd0);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    // reset
    step();
    step();
    check("reset_disp", {disp_hour10, disp_hour, disp_min10, disp_min},
          {4{7'b0000001}});
    check("reset_day_tc", 28'(day_tc), 28'd0);
    check("reset_set_active", 28'(set_active), 28'd0);
    reset = 1'b1;

    //   name                sv s  st c  m  i  reps min hr set
    add("enter_set_min",     0, 0, 0, 0, 1, 0, 1,   0,  0, 1);
    add("inc_min_59",        0, 0, 0, 0, 0, 1, 59, 59,  0, 1);
    add("to_set_hour",       0, 0, 0, 0, 1, 0, 1,  59,  0, 1);
    add("to_run",            0, 0, 0, 0, 1, 0, 1,  59,  0, 0);
    add("carry_to_hour",     0, 1, 0, 0, 0, 0, 1,   0,  1, 0);
    add("sec_run",           0, 1, 0, 0, 0, 0, 3,   3,  1, 0);
    add("set_min_again",     0, 0, 0, 0, 1, 0, 1,   3,  1, 1);
    add("inc_x61",           0, 0, 0, 0, 0, 1, 61,  4,  1, 1);
    add("sec_frozen",        0, 1, 0, 0, 0, 0, 3,   4,  1, 1);
    add("set_hour_b",        0, 0, 0, 0, 1, 0, 1,   4,  1, 1);
    add("back_run",          0, 0, 0, 0, 1, 0, 1,   4,  1, 0);
    add("inc_run_ignored",   0, 0, 0, 0, 0, 1, 2,   4,  1, 0);
    add("mode_inc_min",      0, 0, 0, 0, 1, 1, 1,   5,  1, 1);
    add("mode_inc_hour",     0, 0, 0, 0, 1, 1, 1,   5,  2, 1);
    add("hour_wrap_set",     0, 0, 0, 0, 0, 1, 22,  5,  0, 1);
    add("mode_inc_to_run",   0, 0, 0, 0, 1, 1, 1,   5,  0, 0);
    add("set_min_c",         0, 0, 0, 0, 1, 0, 1,   5,  0, 1);
    add("min_wrap_no_carry", 0, 0, 0, 0, 0, 1, 55,  0,  0, 1);
    add("double_mode_run",   0, 0, 0, 0, 1, 0, 2,   0,  0, 0);
    add("sw_view",           1, 0, 0, 0, 0, 0, 0,   0,  0, 0);
    add("sw_tc_x12",         1, 0, 1, 0, 0, 0, 12, 12,  0, 0);
    add("sw_clear_prio",     1, 0, 1, 1, 0, 0, 1,   0,  0, 0);
    add("sw_enter_set",      1, 0, 0, 0, 1, 0, 1,   0,  0, 1);
    add("sw_in_set",         1, 0, 1, 0, 0, 0, 5,   5,  0, 1);
    add("sw_leave_set",      1, 0, 0, 0, 1, 0, 2,   5,  0, 0);
    add("sw_to_99",          1, 0, 1, 0, 0, 0, 94, 99,  0, 0);
    add("sw_wrap",           1, 0, 1, 0, 0, 0, 1,   0,  0, 0);
    add("sec_hidden",        1, 1, 0, 0, 0, 0, 7,   0,  0, 0);
    add("time_view",         0, 0, 0, 0, 0, 0, 0,   7,  0, 0);
    run_vecs();

    // display lags the counter edge by one cycle
    sec_tc = 1; step(); sec_tc = 0;
    check_disp("lat_before", 0, 7, 0);
    step();
    check_disp("lat_after", 0, 8, 0);

    // preload 23:59 then wrap the day
    add("pre_set_min",       0, 0, 0, 0, 1, 0, 1,   8,  0, 1);
    add("pre_min_59",        0, 0, 0, 0, 0, 1, 51, 59,  0, 1);
    add("pre_set_hour",      0, 0, 0, 0, 1, 0, 1,  59,  0, 1);
    add("pre_hour_23",       0, 0, 0, 0, 0, 1, 23, 59, 23, 1);
    add("pre_run",           0, 0, 0, 0, 1, 0, 1,  59, 23, 0);
    run_vecs();
`ifdef TWELVE_HOUR_EN
    check("pm_at_23", 28'(pm), 28'd1);
`endif
    sec_tc = 1; step(); sec_tc = 0;
    check("day_tc_high", 28'(day_tc), 28'd1);
    step();
    check("day_tc_low", 28'(day_tc), 28'd0);
    check_disp("day_wrap_disp", 0, 0, 0);
`ifdef TWELVE_HOUR_EN
    check("pm_after_wrap", 28'(pm), 28'd0);
`endif

    // reset while in SET_HOUR
    add("rst_prep_mode",     0, 0, 0, 0, 1, 0, 2,   0,  0, 1);
    add("rst_prep_hour",     0, 0, 0, 0, 0, 1, 3,   0,  3, 1);
    run_vecs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rst_mid_disp", {disp_hour10, disp_hour, disp_min10, disp_min},
          {4{7'b0000001}});
    check("rst_mid_set_active", 28'(set_active), 28'd0);
    check("rst_mid_state", 28'(state_dbg), 28'd0);
    add("post_rst_time",     0, 0, 0, 0, 0, 0, 0,   0,  0, 0);
    add("post_rst_sw",       1, 0, 0, 0, 0, 0, 0,   0,  0, 0);
    add("post_rst_run",      0, 1, 0, 0, 0, 0, 1,   1,  0, 0);
    run_vecs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
